// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
//
// Main control FSM of the multicycle processor core. It steps each
// instruction through fetch, decode, execute, memory and writeback, and
// drives every mux select and write strobe of a datapath that shares one
// memory port and one ALU.
//
// Optional feature: define MEM_WAIT_EN to add a mem_ready handshake. FETCH,
// MEMRD and MEMWR then hold until mem_ready=1, and IRWrite, PCWrite and
// MemWrite fire only in the ready cycle. Without the macro, memory always
// completes in one cycle and the port does not exist.
//
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   Op, Funct, Rd   instruction fields, held stable by the IR after FETCH
//   CondEx          condition check result, sampled in DECODE only
//   mem_ready       memory handshake (MEM_WAIT_EN builds only)
//   PCWrite, IRWrite, MemWrite, RegWrite        write strobes
//   AdrSrc, ALUSrcA, ALUSrcB, ResultSrc         datapath mux selects
//   ImmSrc, RegSrc  decoded from Op/Funct in every state
//   ALUOp, Branch   ALU decode enable, branch indicator
//   state           current state encoding, for debug
// -----------------------------------------------------------------------------
module multicycle_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    input  logic       CondEx,
`ifdef MEM_WAIT_EN
    input  logic       mem_ready,
`endif
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       AdrSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc,
    output logic       ALUOp,
    output logic       Branch,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9
    } state_t;

    state_t state_q;
    state_t state_d;

    // Instruction field aliases
    logic       funct_i_s;
    logic       funct_l_s;
    logic [1:0] cmd_hi_s;
    logic       mem_ok_s;
    logic       unused_funct_s;

    assign funct_i_s      = Funct[5];
    assign funct_l_s      = Funct[0];
    assign cmd_hi_s       = Funct[4:3];
    // Only the compare-class bits of cmd matter to the controller
    assign unused_funct_s = ^Funct[2:1];

`ifdef MEM_WAIT_EN
    assign mem_ok_s = mem_ready;
`else
    assign mem_ok_s = 1'b1;
`endif

    // State register with synchronous reset to FETCH
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                if (mem_ok_s) begin
                    state_d = S_DECODE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                // A failed condition or unsupported opcode retires here
                if (!CondEx || (Op == 2'd3)) begin
                    state_d = S_FETCH;
                end else begin
                    case (Op)
                        2'd0: begin
                            if (funct_i_s) begin
                                state_d = S_EXECI;
                            end else begin
                                state_d = S_EXECR;
                            end
                        end
                        2'd1:    state_d = S_MEMADR;
                        2'd2:    state_d = S_BRANCH;
                        default: state_d = S_FETCH;
                    endcase
                end
            end
            S_MEMADR: begin
                if (funct_l_s) begin
                    state_d = S_MEMRD;
                end else begin
                    state_d = S_MEMWR;
                end
            end
            S_MEMRD: begin
                if (mem_ok_s) begin
                    state_d = S_MEMWB;
                end else begin
                    state_d = S_MEMRD;
                end
            end
            S_MEMWR: begin
                if (mem_ok_s) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_MEMWR;
                end
            end
            S_EXECR:  state_d = S_ALUWB;
            S_EXECI:  state_d = S_ALUWB;
            S_MEMWB:  state_d = S_FETCH;
            S_ALUWB:  state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
    end

    // Moore output decode; reset forces every output low, including the
    // Op-derived selects, so nothing is strobed while reset is high
    always_comb begin
        PCWrite   = 1'b0;
        IRWrite   = 1'b0;
        MemWrite  = 1'b0;
        RegWrite  = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'd0;
        ResultSrc = 2'd0;
        ImmSrc    = 2'd0;
        RegSrc    = 2'd0;
        ALUOp     = 1'b0;
        Branch    = 1'b0;
        state     = 4'd0;
        if (reset) begin
            state = 4'd0;
        end else begin
            state     = state_q;
            ImmSrc    = Op;
            RegSrc[0] = (Op == 2'd2);
            RegSrc[1] = (Op == 2'd1) && !funct_l_s;
            case (state_q)
                S_FETCH: begin
                    IRWrite   = mem_ok_s;
                    PCWrite   = mem_ok_s;
                    ALUSrcA   = 1'b1;
                    ALUSrcB   = 2'd2;
                    ResultSrc = 2'd2;
                end
                S_DECODE: begin
                    // PC+4 computed speculatively for PC-relative operands
                    ALUSrcA   = 1'b1;
                    ALUSrcB   = 2'd2;
                    ResultSrc = 2'd2;
                end
                S_MEMADR: begin
                    ALUSrcB = 2'd1;
                end
                S_MEMRD: begin
                    AdrSrc = 1'b1;
                end
                S_MEMWB: begin
                    ResultSrc = 2'd1;
                    RegWrite  = 1'b1;
                    PCWrite   = (Rd == 4'd15);
                end
                S_MEMWR: begin
                    AdrSrc   = 1'b1;
                    MemWrite = mem_ok_s;
                end
                S_EXECR: begin
                    ALUOp = 1'b1;
                end
                S_EXECI: begin
                    ALUSrcB = 2'd1;
                    ALUOp   = 1'b1;
                end
                S_ALUWB: begin
                    // Compare-class commands only update flags
                    RegWrite = (cmd_hi_s != 2'b10);
                    PCWrite  = (cmd_hi_s != 2'b10) && (Rd == 4'd15);
                end
                S_BRANCH: begin
                    ALUSrcB   = 2'd1;
                    ResultSrc = 2'd2;
                    Branch    = 1'b1;
                    PCWrite   = 1'b1;
                end
                default: begin
                    state = state_q;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic       CondEx;
    logic       mem_ready;
    logic       PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, ALUSrcA;
    logic [1:0] ALUSrcB, ResultSrc, ImmSrc, RegSrc;
    logic       ALUOp, Branch;
    logic [3:0] state;

    int checks   = 0;
    int failures = 0;

    multicycle_controller dut (
        .clk       (clk),
        .reset     (reset),
        .Op        (Op),
        .Funct     (Funct),
        .Rd        (Rd),
        .CondEx    (CondEx),
`ifdef MEM_WAIT_EN
        .mem_ready (mem_ready),
`endif
        .PCWrite   (PCWrite),
        .IRWrite   (IRWrite),
        .MemWrite  (MemWrite),
        .RegWrite  (RegWrite),
        .AdrSrc    (AdrSrc),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ResultSrc (ResultSrc),
        .ImmSrc    (ImmSrc),
        .RegSrc    (RegSrc),
        .ALUOp     (ALUOp),
        .Branch    (Branch),
        .state     (state)
    );

    always #5 clk = ~clk;

    logic [19:0] obs;
    assign obs = {PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, ALUSrcA,
                  ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUOp, Branch, state};

    // Output table for one state, straight from the controller description
    function automatic logic [19:0] exp_out(input logic [3:0] st, input logic [1:0] op,
                                            input logic [5:0] f, input logic [3:0] rd,
                                            input logic rdy);
        logic pcw, irw, mw, rw, adr, asa, alu, br;
        logic [1:0] asb, rs, rsrc;
        {pcw, irw, mw, rw, adr, asa, alu, br} = 8'd0;
        asb = 2'd0;
        rs  = 2'd0;
        case (st)
            4'd0: begin irw = rdy; pcw = rdy; asa = 1'b1; asb = 2'd2; rs = 2'd2; end
            4'd1: begin asa = 1'b1; asb = 2'd2; rs = 2'd2; end
            4'd2: asb = 2'd1;
            4'd3: adr = 1'b1;
            4'd4: begin rs = 2'd1; rw = 1'b1; pcw = (rd == 4'd15); end
            4'd5: begin adr = 1'b1; mw = rdy; end
            4'd6: alu = 1'b1;
            4'd7: begin asb = 2'd1; alu = 1'b1; end
            4'd8: begin rw = (f[4:3] != 2'b10); pcw = rw && (rd == 4'd15); end
            4'd9: begin asb = 2'd1; rs = 2'd2; br = 1'b1; pcw = 1'b1; end
            default: ;
        endcase
        rsrc = {(op == 2'd1) && !f[0], op == 2'd2};
        return {pcw, irw, mw, rw, adr, asa, asb, rs, op, rsrc, alu, br, st};
    endfunction

    task automatic check(input string tag, input logic [19:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, obs, expv);
        end
    endtask

    // Called at #1 after the edge that enters FETCH; runs one instruction
    // through the state path implied by its fields and checks every cycle
    task automatic run_instr(input logic [1:0] op, input logic [5:0] f,
                             input logic [3:0] rd, input logic ce, input string tag);
        logic [3:0] path [$];
        Op = op; Funct = f; Rd = rd; CondEx = ce;
        path = '{4'd0, 4'd1};
        if (ce && op != 2'd3) begin
            if (op == 2'd2) path.push_back(4'd9);
            else if (op == 2'd0) begin
                path.push_back(f[5] ? 4'd7 : 4'd6);
                path.push_back(4'd8);
            end else begin
                path.push_back(4'd2);
                if (f[0]) begin path.push_back(4'd3); path.push_back(4'd4); end
                else path.push_back(4'd5);
            end
        end
        #1;
        foreach (path[i]) begin
            if (i > 0) begin @(posedge clk); #1; end
            check(tag, exp_out(path[i], op, f, rd, 1'b1));
        end
        @(posedge clk); #1;
    endtask

    initial begin
        reset = 1'b1; Op = 2'd2; Funct = 6'b000000; Rd = 4'd15; CondEx = 1'b1;
        mem_ready = 1'b1;
        // Reset held three cycles: everything must read zero
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            Op = 2'($urandom_range(0, 3));
            #1;
            check("reset_zero", 20'd0);
        end
        reset = 1'b0;
        // First post-reset cycle is FETCH with IRWrite/PCWrite (checked inside)
        run_instr(2'd0, 6'b101000, 4'd3, 1'b1, "add_imm");
        run_instr(2'd1, 6'b011001, 4'd15, 1'b1, "ldr_pc");
        run_instr(2'd1, 6'b011000, 4'd7, 1'b1, "str");
        run_instr(2'd2, 6'b000000, 4'd0, 1'b0, "branch_nc");
        run_instr(2'd2, 6'b000000, 4'd0, 1'b1, "branch");
        run_instr(2'd0, 6'b010101, 4'd15, 1'b1, "cmp_rd15");
        run_instr(2'd0, 6'b001000, 4'd15, 1'b1, "add_reg_pc");
        run_instr(2'd3, 6'b111111, 4'd1, 1'b1, "op3");

        // Reset in MEMWB of LDR PC: strobes must stay low, then clean FETCH
        Op = 2'd1; Funct = 6'b011001; Rd = 4'd15; CondEx = 1'b1;
        #1 check("abort_fetch", exp_out(4'd0, Op, Funct, Rd, 1'b1));
        for (int i = 1; i < 5; i++) begin
            @(posedge clk); #1;
        end
        check("abort_memwb", exp_out(4'd4, Op, Funct, Rd, 1'b1));
        reset = 1'b1;
        #1 check("abort_reset", 20'd0);
        @(posedge clk); #1;
        check("abort_reset2", 20'd0);
        reset = 1'b0;
        run_instr(2'd1, 6'b011001, 4'd2, 1'b1, "after_abort");

`ifdef MEM_WAIT_EN
        // Store with two wait cycles in MEMWR
        Op = 2'd1; Funct = 6'b011000; Rd = 4'd2; CondEx = 1'b1;
        #1 check("wait_fetch", exp_out(4'd0, Op, Funct, Rd, 1'b1));
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("wait_memadr", exp_out(4'd2, Op, Funct, Rd, 1'b1));
        @(posedge clk); #1;
        mem_ready = 1'b0;
        #1 check("wait_memwr0", exp_out(4'd5, Op, Funct, Rd, 1'b0));
        @(posedge clk); #1;
        check("wait_memwr1", exp_out(4'd5, Op, Funct, Rd, 1'b0));
        mem_ready = 1'b1;
        #1 check("wait_memwr2", exp_out(4'd5, Op, Funct, Rd, 1'b1));
        @(posedge clk); #1;
`endif

        // Randomised instruction stream
        for (int n = 0; n < 40; n++) begin
            logic [1:0] r_op;
            logic [5:0] r_f;
            logic [3:0] r_rd;
            logic       r_ce;
            r_op = 2'($urandom_range(0, 3));
            r_f  = 6'($urandom);
            r_rd = ($urandom_range(0, 2) == 0) ? 4'd15 : 4'($urandom_range(0, 15));
            r_ce = ($urandom_range(0, 4) != 0);
            run_instr(r_op, r_f, r_rd, r_ce, "random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Main control FSM for the multicycle version of the processor core. It replaces the combinational main decoder with a sequenced controller. The datapath shares one memory port for instructions and data, plus one ALU for PC increment, address generation and execute. The controller steps each instruction through fetch, decode, execute, memory and writeback states, and drives every mux select and write strobe of that datapath.

## Interface
Parameters:
- none

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- Op  in  2  instruction[27:26]: 0 data-processing, 1 memory, 2 branch, 3 unsupported
- Funct  in  6  instruction[25:20]: Funct[5]=I, Funct[0]=L (memory) or S (data-processing), Funct[4:1]=cmd
- Rd  in  4  destination register field
- CondEx  in  1  condition check result for the current instruction; valid in DECODE
- PCWrite  out  1  PC register enable
- IRWrite  out  1  instruction register enable
- MemWrite  out  1  memory write strobe
- RegWrite  out  1  register file write strobe
- AdrSrc  out  1  memory address: 0 = PC, 1 = ALU result register
- ALUSrcA  out  1  0 = register A, 1 = PC
- ALUSrcB  out  2  0 = register B, 1 = extended immediate, 2 = constant 4
- ResultSrc  out  2  0 = ALU result register, 1 = data register, 2 = ALU output
- ImmSrc  out  2  extender mode; equals Op
- RegSrc  out  2  register-file read address selects
- ALUOp  out  1  1 = decode Funct for the ALU; 0 = add
- Branch  out  1  asserted in BRANCH state
- state  out  4  current state encoding, for debug

## Operation
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9.
- Any unused encoding goes to FETCH on the next edge.
- Transitions:
  - FETCH -> DECODE.
  - DECODE -> FETCH if CondEx=0 or Op=3.
  - DECODE -> MEMADR if Op=1.
  - DECODE -> EXECI if Op=0 and I=1.
  - DECODE -> EXECR if Op=0 and I=0.
  - DECODE -> BRANCH if Op=2.
  - MEMADR -> MEMRD if L=1, else MEMWR.
  - MEMRD -> MEMWB.
  - EXECR and EXECI -> ALUWB.
  - MEMWB, MEMWR, ALUWB and BRANCH -> FETCH.
- Outputs are decoded from state (Moore). Any output not listed for a state is 0.
  - FETCH: IRWrite=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=2, ALUOp=0, ResultSrc=2, PCWrite=1.
  - DECODE: ALUSrcA=1, ALUSrcB=2, ResultSrc=2.
  - MEMADR: ALUSrcA=0, ALUSrcB=1, ALUOp=0.
  - MEMRD: AdrSrc=1, ResultSrc=0.
  - MEMWB: ResultSrc=1, RegWrite=1.
  - MEMWR: AdrSrc=1, MemWrite=1.
  - EXECR: ALUSrcA=0, ALUSrcB=0, ALUOp=1.
  - EXECI: ALUSrcA=0, ALUSrcB=1, ALUOp=1.
  - ALUWB: ResultSrc=0, RegWrite=1.
  - BRANCH: ALUSrcA=0, ALUSrcB=1, ResultSrc=2, Branch=1, PCWrite=1.
- In ALUWB, RegWrite=0 when Funct[4:3]=2'b10 (TST/TEQ/CMP/CMN).
- Writes to PC:
  - In MEMWB, when Rd=15: PCWrite=1 together with RegWrite.
  - In ALUWB, when Rd=15 and RegWrite=1: PCWrite=1.
- ImmSrc and RegSrc are combinational from Op and Funct in every state:
  - ImmSrc = Op.
  - RegSrc[0] = (Op==2).
  - RegSrc[1] = (Op==1 and L==0).

## Timing
- While reset=1: state=FETCH and all outputs are 0. This overrides the FETCH decode and applies to every strobe and select.
- The first cycle after reset deasserts is a FETCH, with IRWrite=1 and PCWrite=1.
- Reset asserted mid-instruction aborts it at the next edge. No memory write or register write occurs in a cycle where reset=1.
- Instruction latency in cycles:
  - Branch: 3.
  - Data-processing: 4.
  - Store: 4.
  - Load: 5.
  - Condition-failed or Op=3: 2.
- CondEx is sampled only in DECODE. Op, Funct and Rd must stay stable from DECODE until the return to FETCH; the IR holds them.

## Configuration
- MEM_WAIT_EN defined:
  - Adds input mem_ready (1 bit).
  - FETCH, MEMRD and MEMWR hold their state while mem_ready=0.
  - IRWrite, PCWrite and MemWrite assert only in the cycle with mem_ready=1. The strobe outputs are held at 0 while waiting.
  - Latencies grow by one cycle per wait cycle.
- MEM_WAIT_EN undefined:
  - No mem_ready port.
  - Memory completes in one cycle, with the latencies listed in Timing.

## Test plan
- Reset held for 3 cycles, then released -> all outputs 0 during reset. Next cycle: state=0, IRWrite=1, PCWrite=1.
- Op=0, Funct=6'b101000 (ADD immediate), Rd=3, CondEx=1 -> states 0,1,7,8,0. In state 8: RegWrite=1, PCWrite=0.
- Op=1, Funct=6'b011001 (LDR), Rd=15 -> states 0,1,2,3,4. In state 4: RegWrite=1, PCWrite=1, ResultSrc=1.
- Op=1, L=0 (STR) -> RegSrc=2 in DECODE. In state 5: MemWrite=1, AdrSrc=1, and no RegWrite.
- Op=2 with CondEx=0 -> DECODE then back to 0, with no PCWrite in DECODE. Same instruction with CondEx=1 -> state 9 with Branch=1, PCWrite=1.
- MEM_WAIT_EN defined, mem_ready low for 2 cycles during MEMWR -> state 5 is held for 3 cycles and MemWrite pulses once, in the last of them.
